// File: rtl/fp_exp_pkg.sv
// Shared types and constants for the FP exponent step adjuster.
package fp_exp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } exp_adj_state_t;

    localparam int FP16_EXP_W = 5;

endpackage

// File: rtl/exp_step_unit.sv
// Combinational +/-1 stage for a biased exponent.
// carry flags the all-ones -> 0 wrap of an increment, borrow flags the
// 0 -> all-ones wrap of a decrement.
module exp_step_unit #(
    parameter int EXP_W = 5
) (
    input  logic [EXP_W-1:0] a,
    input  logic             dec,
    output logic [EXP_W-1:0] s,
    output logic             carry,
    output logic             borrow
);

    assign s      = dec ? (a - EXP_W'(1)) : (a + EXP_W'(1));
    assign carry  = !dec && (a == '1);
    assign borrow = dec && (a == '0);

endmodule

// File: rtl/fp_exp_step_adjuster.sv
// Multi-cycle exponent adjuster: applies steps_in unit steps (+1 or -1) to a
// biased exponent, one step per clock, with overflow/underflow flags.
// Build option: define FP_EXP_SAT_EN for saturating mode (stop at all-ones
// or zero); leave it undefined for wrapping mode with sticky wrap flags.
//
//   state | meaning
//   IDLE  | waiting for a request, in_ready high
//   RUN   | one unit step applied per clock, count decrementing
//   DONE  | result held on exp_out/ovf/unf with out_valid until out_ready
module fp_exp_step_adjuster #(
    parameter int EXP_W  = fp_exp_pkg::FP16_EXP_W,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [STEP_W-1:0] steps_in,
    input  logic              dir_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EXP_W-1:0]  exp_out,
    output logic              ovf,
    output logic              unf
);

    import fp_exp_pkg::*;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    exp_adj_state_t    state_q, state_nxt;
    logic [EXP_W-1:0]  exp_q, exp_nxt;
    logic [STEP_W-1:0] cnt_q, cnt_nxt;
    logic              dir_q, dir_nxt;
    logic              ovf_q, ovf_nxt;
    logic              unf_q, unf_nxt;

    logic [EXP_W-1:0]  step_s;
    logic              step_carry;
    logic              step_borrow;

    exp_step_unit #(.EXP_W(EXP_W)) u_step (
        .a      (exp_q),
        .dec    (dir_q),
        .s      (step_s),
        .carry  (step_carry),
        .borrow (step_borrow)
    );

`ifdef FP_EXP_SAT_EN
    // Saturating mode detects boundaries on the stepped value, so the wrap flags go unused.
    logic unused_wrap;
    assign unused_wrap = step_carry | step_borrow;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Exponent, count, direction and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
            cnt_q <= '0;
            dir_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            exp_q <= exp_nxt;
            cnt_q <= cnt_nxt;
            dir_q <= dir_nxt;
            ovf_q <= ovf_nxt;
            unf_q <= unf_nxt;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state_q;
        exp_nxt   = exp_q;
        cnt_nxt   = cnt_q;
        dir_nxt   = dir_q;
        ovf_nxt   = ovf_q;
        unf_nxt   = unf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    exp_nxt = exp_in;
                    cnt_nxt = steps_in;
                    dir_nxt = dir_in;
                    ovf_nxt = 1'b0;
                    unf_nxt = 1'b0;
                    if (steps_in == '0) begin
                        state_nxt = DONE;
`ifdef FP_EXP_SAT_EN
                    // Already at the boundary: flag it and skip RUN entirely.
                    end else if (!dir_in && (exp_in == EXP_MAX)) begin
                        ovf_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else if (dir_in && (exp_in == '0)) begin
                        unf_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                exp_nxt = step_s;
                cnt_nxt = cnt_q - STEP_W'(1);
`ifdef FP_EXP_SAT_EN
                // Stop in the cycle the boundary is reached; leftover steps are dropped.
                if (!dir_q && (step_s == EXP_MAX)) begin
                    ovf_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else if (dir_q && (step_s == '0)) begin
                    unf_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = DONE;
                end else if (cnt_q == STEP_W'(1)) begin
                    state_nxt = DONE;
                end
`else
                ovf_nxt = ovf_q | step_carry;
                unf_nxt = unf_q | step_borrow;
                if (cnt_q == STEP_W'(1)) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign exp_out   = exp_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;

endmodule

// File: tb/tb_fp_exp_step_adjuster.sv
// Randomised self-checking bench for fp_exp_step_adjuster (EXP_W=5, STEP_W=4).
// Follows FP_EXP_SAT_EN the same way the design does.
module tb_fp_exp_step_adjuster;

    localparam int EXP_W  = 5;
    localparam int STEP_W = 4;
    localparam int MAXE   = (1 << EXP_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [EXP_W-1:0]  exp_in;
    logic [STEP_W-1:0] steps_in;
    logic              dir_in;
    logic              out_valid;
    logic              out_ready;
    logic [EXP_W-1:0]  exp_out;
    logic              ovf;
    logic              unf;

    fp_exp_step_adjuster #(.EXP_W(EXP_W), .STEP_W(STEP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_in    (exp_in),
        .steps_in  (steps_in),
        .dir_in    (dir_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .exp_out   (exp_out),
        .ovf       (ovf),
        .unf       (unf)
    );

    typedef struct {
        int e;
        int o;
        int u;
        int lat;
    } res_t;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Outstanding request bookkeeping: driver owns req_cnt/abort_cnt, the
    // compare process owns rsp_cnt.
    int   req_cnt   = 0;
    int   rsp_cnt   = 0;
    int   abort_cnt = 0;
    int   acc_cyc   = 0;
    int   due_cyc   = 0;
    res_t exp_res;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Result from the arithmetic rules: final exponent, flags and accept-to-valid latency.
    function automatic res_t model(input int e0, input int n, input int dec);
        res_t r;
        int   d;
        r.o   = 0;
        r.u   = 0;
        r.lat = n + 1;
`ifdef FP_EXP_SAT_EN
        if (n == 0) begin
            r.e = e0;
        end else if (dec == 0) begin
            d = MAXE - e0;
            if (n >= d) begin
                r.e   = MAXE;
                r.o   = 1;
                r.lat = (d == 0) ? 1 : d + 1;
            end else begin
                r.e = e0 + n;
            end
        end else begin
            d = e0;
            if (n >= d) begin
                r.e   = 0;
                r.u   = 1;
                r.lat = (d == 0) ? 1 : d + 1;
            end else begin
                r.e = e0 - n;
            end
        end
`else
        if (dec == 0) begin
            r.e = (e0 + n) % (MAXE + 1);
            r.o = (e0 + n > MAXE) ? 1 : 0;
        end else begin
            r.e = (e0 - n + MAXE + 1) % (MAXE + 1);
            r.u = (n > e0) ? 1 : 0;
        end
`endif
        return r;
    endfunction

    // Per-cycle comparison of every observable output against the expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_cnt != rsp_cnt + abort_cnt) begin
                check("in_ready", {31'd0, in_ready}, (cyc < acc_cyc) ? 32'd1 : 32'd0);
                check("out_valid", {31'd0, out_valid}, (cyc >= due_cyc) ? 32'd1 : 32'd0);
                if (out_valid) begin
                    check("exp_out", {27'd0, exp_out}, exp_res.e);
                    check("ovf", {31'd0, ovf}, exp_res.o);
                    check("unf", {31'd0, unf}, exp_res.u);
                    if (out_ready) rsp_cnt = rsp_cnt + 1;
                end
            end else begin
                check("idle_in_ready", {31'd0, in_ready}, 32'd1);
                check("idle_out_valid", {31'd0, out_valid}, 32'd0);
            end
        end
    end

    // Issue one request (driven #1 after a rising edge) without waiting for its result.
    task automatic issue(input int e0, input int n, input int dec, input bit early_rdy);
        @(posedge clk);
        #1;
        exp_res   = model(e0, n, dec);
        acc_cyc   = cyc + 1;
        due_cyc   = cyc + exp_res.lat;
        exp_in    = e0[EXP_W-1:0];
        steps_in  = n[STEP_W-1:0];
        dir_in    = dec[0];
        out_ready = early_rdy;
        in_valid  = 1'b1;
        req_cnt   = req_cnt + 1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        exp_in    = EXP_W'($urandom);
        steps_in  = STEP_W'($urandom);
        dir_in    = 1'($urandom);
    endtask

    // Full transaction: request, optional out_ready back-pressure, completion.
    task automatic run_req(input int e0, input int n, input int dec, input int hold, input bit early_rdy);
        int t;
        issue(e0, n, dec, early_rdy && (hold == 0));
        if (!(early_rdy && (hold == 0))) begin
            t = 0;
            while (!out_valid && t < 40) begin
                @(posedge clk);
                #1;
                t++;
            end
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            out_ready = 1'b1;
        end
        t = 0;
        while ((req_cnt != rsp_cnt + abort_cnt) && t < 60) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (req_cnt != rsp_cnt + abort_cnt) begin
            check("completion_timeout", 32'd0, 32'd1);
            abort_cnt = abort_cnt + 1;
        end
        out_ready = 1'b0;
    endtask

    initial begin
        res_t r;
        int   e0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        exp_in    = '0;
        steps_in  = '0;
        dir_in    = 1'b0;
        out_ready = 1'b0;

        // Hand-computed anchors for the model.
        r = model(10, 3, 0);
        check("pin_inc_e", r.e, 13);
        check("pin_inc_lat", r.lat, 4);
        r = model(7, 0, 0);
        check("pin_zero_lat", r.lat, 1);
`ifdef FP_EXP_SAT_EN
        r = model(2, 5, 1);
        check("pin_dec_e", r.e, 0);
        check("pin_dec_u", r.u, 1);
        check("pin_dec_lat", r.lat, 3);
        r = model(30, 4, 0);
        check("pin_ovf_e", r.e, 31);
        check("pin_ovf_o", r.o, 1);
`else
        r = model(2, 5, 1);
        check("pin_dec_e", r.e, 29);
        check("pin_dec_u", r.u, 1);
        check("pin_dec_lat", r.lat, 6);
        r = model(30, 4, 0);
        check("pin_ovf_e", r.e, 2);
        check("pin_ovf_o", r.o, 1);
`endif

        // Reset values.
        #12;
        check("rst_exp_out", {27'd0, exp_out}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_unf", {31'd0, unf}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases.
        run_req(10, 3, 0, 0, 1'b1);
        run_req(2, 5, 1, 0, 1'b1);
        run_req(30, 4, 0, 0, 1'b0);
        run_req(7, 0, 0, 0, 1'b1);
        run_req(31, 2, 0, 0, 1'b1);
        run_req(0, 3, 1, 0, 1'b0);
        run_req(31, 0, 0, 1, 1'b0);
        run_req(0, 0, 1, 0, 1'b1);
        run_req(20, 15, 1, 5, 1'b0);
        run_req(29, 2, 0, 5, 1'b0);

        // Reset mid-RUN: outputs clear at once, request is dropped.
        issue(10, 15, 0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        abort_cnt = abort_cnt + 1;
        rst_n = 1'b0;
        #1;
        check("midrst_exp_out", {27'd0, exp_out}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        check("midrst_unf", {31'd0, unf}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("postrst_in_ready", {31'd0, in_ready}, 32'd1);

        // Randomised requests, biased toward the exponent boundaries.
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0: e0 = $urandom_range(0, 3);
                1: e0 = $urandom_range(MAXE - 3, MAXE);
                default: e0 = $urandom_range(0, MAXE);
            endcase
            run_req(e0, $urandom_range(0, 15), $urandom_range(0, 1),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0,
                    1'($urandom));
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
